// File: rtl/comp_a2_pkg.sv
// Shared constants, the most-negative-pattern helper and the status flag struct for comp_a2.
// Optional saturation (COMP_A2_SAT_EN) is handled in comp_a2_core.
package comp_a2_pkg;

    localparam int COMP_A2_W = 4;

    // Returns 1 followed by (width-1) zeros, right-aligned in a 32-bit word.
    function automatic logic [31:0] neg_min(input int width);
        return 32'h1 << (width - 1);
    endfunction

    typedef struct packed {
        logic ovf;
        logic zero;
    } comp_a2_status_t;

endpackage

// File: rtl/comp_a2_core.sv
// Combinational two's-complement negate (invert, then ripple increment) with ovf/zero flags.
// When COMP_A2_SAT_EN is defined, negating the most-negative value saturates to max positive.
module comp_a2_core
    import comp_a2_pkg::*;
#(
    parameter int WIDTH = COMP_A2_W
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] s,
    output comp_a2_status_t  status
);

    localparam logic [31:0]      MIN_FULL = neg_min(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = MIN_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] inv;
    logic [WIDTH-1:0] sum;
    logic             carry;

    always_comb begin
        inv   = ~a;
        sum   = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = inv[i] ^ carry;
            carry  = inv[i] & carry;
        end
    end

    always_comb begin
        status.ovf  = (a == MIN_VAL);
        status.zero = (a == '0);
`ifdef COMP_A2_SAT_EN
        s = status.ovf ? ~MIN_VAL : sum;
`else
        s = sum;
`endif
    end

endmodule

// File: rtl/comp_a2.sv
// Registered two's-complement negator: one-cycle stage with valid strobe and ovf/zero flags.
// Build option COMP_A2_SAT_EN selects saturation on the most-negative input (see comp_a2_core).
module comp_a2
    import comp_a2_pkg::*;
#(
    parameter int WIDTH = COMP_A2_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH-1:0] s_next;
    comp_a2_status_t  status_next;

    comp_a2_core #(.WIDTH(WIDTH)) u_core (
        .a      (a),
        .s      (s_next),
        .status (status_next)
    );

    // Result registers hold their value while in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= s_next;
                ovf  <= status_next.ovf;
                zero <= status_next.zero;
            end
        end
    end

endmodule

// File: tb/tb_comp_a2.sv
// Self-checking bench for comp_a2 (WIDTH = 4) against an arithmetic reference model.
module tb_comp_a2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = 4'h0;
    logic       out_valid;
    logic [3:0] s;
    logic       ovf;
    logic       zero;

    int checks = 0;
    int passed = 0;

    // reference model state: what the outputs should show right now
    logic       m_valid = 1'b0;
    logic [3:0] m_s = 4'h0;
    logic       m_ovf = 1'b0;
    logic       m_zero = 1'b0;

    comp_a2 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid),
        .s         (s),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic int negate(input int v);
        int r;
        r = (16 - v) % 16;
`ifdef COMP_A2_SAT_EN
        if (v == 8) r = 7;
`endif
        return r;
    endfunction

    task automatic drive(input bit v, input logic [3:0] val);
        in_valid = v;
        a        = val;
        @(posedge clk);
        #1;
        m_valid = v;
        if (v) begin
            m_s    = 4'(negate(int'(val)));
            m_ovf  = (val == 4'd8);
            m_zero = (val == 4'd0);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_s     = 4'h0;
        m_ovf   = 1'b0;
        m_zero  = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if ({out_valid, ovf, zero, s} !== 7'b0) $display("FAIL reset_initial got %b want %b", {out_valid, ovf, zero, s}, 7'b0);
        else passed++;
        rst = 1'b0;
        drive(1'b1, 4'b1101);
        checks++;
        if ({out_valid, ovf, zero, s} !== {m_valid, m_ovf, m_zero, m_s}) $display("FAIL reset_pre_op got %b want %b", {out_valid, ovf, zero, s}, {m_valid, m_ovf, m_zero, m_s});
        else passed++;
        // assert rst mid-cycle with in_valid high; outputs must clear with no clock edge
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({out_valid, ovf, zero, s} !== 7'b0) $display("FAIL reset_async got %b want %b", {out_valid, ovf, zero, s}, 7'b0);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, ovf, zero, s} !== 7'b0) $display("FAIL reset_hold got %b want %b", {out_valid, ovf, zero, s}, 7'b0);
        else passed++;
        #2;
        rst = 1'b0;
        drive(1'b0, 4'b1101);
        checks++;
        if ({out_valid, ovf, zero, s} !== {m_valid, m_ovf, m_zero, m_s}) $display("FAIL reset_no_stale got %b want %b", {out_valid, ovf, zero, s}, {m_valid, m_ovf, m_zero, m_s});
        else passed++;
    endtask

    task automatic test_directed();
        logic [3:0] vals [5] = '{4'b1101, 4'b1111, 4'b1001, 4'b0000, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vals[i]);
            checks++;
            if ({out_valid, ovf, zero, s} !== {m_valid, m_ovf, m_zero, m_s}) $display("FAIL directed a=%b got %b want %b", vals[i], {out_valid, ovf, zero, s}, {m_valid, m_ovf, m_zero, m_s});
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [4] = '{4'b1101, 4'b1111, 4'b1101, 4'b1001};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i]);
            checks++;
            if ({out_valid, ovf, zero, s} !== {1'b1, m_ovf, m_zero, m_s}) $display("FAIL stream idx=%0d got %b want %b", i, {out_valid, ovf, zero, s}, {1'b1, m_ovf, m_zero, m_s});
            else passed++;
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 4'b1101);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'($urandom_range(0, 15)));
            checks++;
            if ({out_valid, s} !== {1'b0, 4'b0011}) $display("FAIL hold cyc=%0d got %b want %b", i, {out_valid, s}, {1'b0, 4'b0011});
            else passed++;
        end
    endtask

    task automatic test_sweep();
        logic [3:0] first;
        for (int v = 0; v < 16; v++) begin
            drive(1'b1, 4'(v));
            checks++;
            if ({out_valid, ovf, zero, s} !== {m_valid, m_ovf, m_zero, m_s}) $display("FAIL sweep a=%0d got %b want %b", v, {out_valid, ovf, zero, s}, {m_valid, m_ovf, m_zero, m_s});
            else passed++;
            first = m_s;
            drive(1'b1, first);
            checks++;
            if (s !== 4'(negate(negate(v)))) $display("FAIL double_neg a=%0d got %0d want %0d", v, s, negate(negate(v)));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            checks++;
            if ({out_valid, ovf, zero, s} !== {m_valid, m_ovf, m_zero, m_s}) $display("FAIL random i=%0d got %b want %b", i, {out_valid, ovf, zero, s}, {m_valid, m_ovf, m_zero, m_s});
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
